// File: rtl/seg_scan_decoder_if.sv
// Scan-bus interface for the multiplexed 7-segment display.
// The master drives the bus (display scanner); the slave watches it (decoder).
interface seg_scan_decoder_if;
   logic [6:0] seg;      // {a,b,c,d,e,f,g}, active-high
   logic       seg_dp;   // decimal point of the enabled digit
   logic [5:0] seg_enb;  // active-low one-hot digit enables

   modport master (
      output seg,
      output seg_dp,
      output seg_enb
   );

   modport slave (
      input  seg,
      input  seg_dp,
      input  seg_enb
   );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of the multiplexed 7-segment scan bus.
// Filters the scanned bus, decodes each settled digit back to a nibble plus
// decimal point, and publishes a coherent six-digit snapshot once every
// slot has been captured. Also flags illegal bus content and a stopped scan.
module seg_scan_decoder #(
   parameter int unsigned SETTLE_CYC = 4,
   parameter logic [31:0] TIMEOUT    = 32'd20000
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_scan_decoder_if.slave i_scan,
   input  logic              i_err_clr,
   output logic [23:0]       o_digits,
   output logic [5:0]        o_dp,
   output logic              o_frame_done,
   output logic              o_err,
   output logic              o_stalled
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_HOLD
   } state_t;

   // Counter value at which the bus has been stable long enough to capture.
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

   // Inverse of the display encoder: {illegal, nibble}.
   // Blank (all segments off) is legal and reads back as F.
   function automatic logic [4:0] f_decode(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'h7E:   res = 5'h00;
         7'h30:   res = 5'h01;
         7'h6D:   res = 5'h02;
         7'h79:   res = 5'h03;
         7'h33:   res = 5'h04;
         7'h5B:   res = 5'h05;
         7'h5F:   res = 5'h06;
         7'h70:   res = 5'h07;
         7'h7F:   res = 5'h08;
         7'h73:   res = 5'h09;
         7'h00:   res = 5'h0F;
         default: res = 5'h1E;
      endcase
      return res;
   endfunction

   // Registered bus copy and the copy from one cycle earlier.
   logic [6:0]  r_seg;
   logic        r_dp;
   logic [5:0]  r_enb;
   logic [6:0]  r_seg_prev;
   logic        r_dp_prev;
   logic [5:0]  r_enb_prev;

   // FSM state and settle counter.
   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_settle_cnt;
   logic [7:0]  w_settle_cnt_next;

   // Frame assembly.
   logic [5:0]  r_mask;
   logic [5:0]  w_mask_next;
   logic        r_pub_pend;
   logic [23:0] r_digits;
   logic [5:0]  r_dp_out;
   logic        r_frame_done;
   logic [23:0] w_shadow_digits;
   logic [5:0]  w_shadow_dp;
   logic [5:0]  w_slot_sel;

   // Status.
   logic        r_err;
   logic [31:0] r_to_cnt;

   // Combinational helpers.
   logic        w_bus_changed;
   logic        w_enb_changed;
   logic        w_enb_valid;
   logic        w_enb_gap;
   logic        w_enb_illegal;
   logic        w_capture;
   logic [4:0]  w_cap_dec;

   assign w_bus_changed = {r_seg, r_dp, r_enb} != {r_seg_prev, r_dp_prev, r_enb_prev};
   assign w_enb_changed = r_enb != r_enb_prev;
   assign w_enb_valid   = $onehot(~r_enb);
   assign w_enb_gap     = r_enb == 6'h3F;

   // Capture always uses the previous registered copy: it is the value that
   // stayed stable through the settle window, even if the bus moves on in
   // the capture cycle itself.
   assign w_cap_dec     = f_decode(r_seg_prev);

   // Input stage: one register on the pins, one more for change detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg      <= 7'h00;
         r_dp       <= 1'b0;
         r_enb      <= 6'h3F;
         r_seg_prev <= 7'h00;
         r_dp_prev  <= 1'b0;
         r_enb_prev <= 6'h3F;
      end else begin
         r_seg      <= i_scan.seg;
         r_dp       <= i_scan.seg_dp;
         r_enb      <= i_scan.seg_enb;
         r_seg_prev <= r_seg;
         r_dp_prev  <= r_dp;
         r_enb_prev <= r_enb;
      end
   end

   // FSM state register and settle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_settle_cnt <= 8'd0;
      end else begin
         r_state      <= w_state_next;
         r_settle_cnt <= w_settle_cnt_next;
      end
   end

   // Next-state logic: any bus change re-classifies the enables, whatever
   // the current state; otherwise the state advances on stability.
   always_comb begin
      w_state_next      = r_state;
      w_settle_cnt_next = r_settle_cnt;
      w_capture         = 1'b0;
      w_enb_illegal     = 1'b0;

      case (r_state)
         ST_SETTLE: begin
            if (r_settle_cnt + 8'd1 == SETTLE_LAST) begin
               w_state_next = ST_CAPTURE;
            end else begin
               w_settle_cnt_next = r_settle_cnt + 8'd1;
            end
         end
         ST_CAPTURE: begin
            w_capture    = 1'b1;
            w_state_next = ST_HOLD;
         end
         default: begin
            // IDLE waits for a change; HOLD allows one capture per dwell.
         end
      endcase

      if (w_bus_changed) begin
         w_settle_cnt_next = 8'd0;
         if (w_enb_valid) begin
            w_state_next = (SETTLE_CYC == 1) ? ST_CAPTURE : ST_SETTLE;
         end else begin
            w_state_next  = ST_IDLE;
            w_enb_illegal = !w_enb_gap;
         end
      end
   end

   // A new capture after a completed frame starts the next frame's mask.
   assign w_mask_next = (r_pub_pend ? 6'h00 : r_mask) | w_slot_sel;

   // One shadow slot per digit; only the slot whose enable is active is written.
   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_slot
         logic [3:0] r_nib;
         logic       r_sdp;

         assign w_slot_sel[gi] = w_capture & ~r_enb_prev[gi];

         // Latest capture for this digit wins until the frame is published.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_nib <= 4'hF;
               r_sdp <= 1'b0;
            end else if (w_slot_sel[gi]) begin
               r_nib <= w_cap_dec[3:0];
               r_sdp <= r_dp_prev;
            end
         end

         assign w_shadow_digits[4*gi +: 4] = r_nib;
         assign w_shadow_dp[gi]            = r_sdp;
      end
   endgenerate

   // Frame tracking and publication of the complete snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask       <= 6'h00;
         r_pub_pend   <= 1'b0;
         r_digits     <= 24'hFFFFFF;
         r_dp_out     <= 6'h00;
         r_frame_done <= 1'b0;
      end else begin
         r_mask       <= w_mask_next;
         r_pub_pend   <= w_capture && (w_mask_next == 6'h3F);
         r_frame_done <= r_pub_pend;
         if (r_pub_pend) begin
            r_digits <= w_shadow_digits;
            r_dp_out <= w_shadow_dp;
         end
      end
   end

   // Sticky error: illegal enables or an illegal captured segment code; set beats clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (w_enb_illegal || (w_capture && w_cap_dec[4])) begin
         r_err <= 1'b1;
      end else if (i_err_clr) begin
         r_err <= 1'b0;
      end
   end

   // Stall detector: cycles since the last enable change, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= 32'd0;
      end else if (w_enb_changed) begin
         r_to_cnt <= 32'd0;
      end else if (r_to_cnt != TIMEOUT) begin
         r_to_cnt <= r_to_cnt + 32'd1;
      end
   end

   assign o_digits     = r_digits;
   assign o_dp         = r_dp_out;
   assign o_frame_done = r_frame_done;
   assign o_err        = r_err;
   assign o_stalled    = r_to_cnt == TIMEOUT;

endmodule
